// File: rtl/ex_muldiv_ctrl_if.sv
// ex_muldiv_ctrl_if: execute-stage multiply/divide handshake and operand bus
interface ex_muldiv_ctrl_if;
  logic        StartE;
  logic [2:0]  MDOpE;
  logic [31:0] srcA;
  logic [31:0] srcB;
  logic        FlushE;
  logic        StallE;
  logic        MDDoneE;
  logic [31:0] MDResultE;
  modport master (output StartE, MDOpE, srcA, srcB, FlushE, input StallE, MDDoneE, MDResultE);
  modport slave  (input StartE, MDOpE, srcA, srcB, FlushE, output StallE, MDDoneE, MDResultE);
endinterface

// File: rtl/ex_muldiv_ctrl.sv
// ex_muldiv_ctrl: iterative RV32M multiply/divide unit, 32 radix-2 steps; MULDIV_EARLY_OUT_EN enables early completion
module ex_muldiv_ctrl (
  input logic             clk,
  input logic             rst,
  ex_muldiv_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] x_q, x_d, y_q, y_d, m_q, m_d, res_q, res_d;
  logic [2:0]  op_q, op_d;
  logic        neg_q, neg_d;
  logic        sa, sb, busy;
  logic [31:0] ma, mb, x_n, y_n, dv, fin;
  logic [32:0] hs, sh, diff;
  logic [63:0] prod;
`ifdef MULDIV_EARLY_OUT_EN
  logic        early;
  logic [31:0] eo_res;
`endif
  // datapath: operand magnitudes, one shift-add or restoring-divide step, final sign fixup
  always_comb begin
    sa = bus.srcA[31] & (bus.MDOpE[2] ? ~bus.MDOpE[0] : bus.MDOpE[1] ^ bus.MDOpE[0]);
    sb = bus.srcB[31] & (bus.MDOpE[2] ? ~bus.MDOpE[0] : bus.MDOpE[1:0] == 2'd1);
    ma = sa ? -bus.srcA : bus.srcA;
    mb = sb ? -bus.srcB : bus.srcB;
    hs = {1'b0, x_q} + (y_q[0] ? {1'b0, m_q} : 33'd0);
    sh = {x_q, y_q[31]};
    diff = sh - {1'b0, m_q};
    x_n = state_q == MUL ? hs[32:1] : (diff[32] ? sh[31:0] : diff[31:0]);
    y_n = state_q == MUL ? {hs[0], y_q[31:1]} : {y_q[30:0], ~diff[32]};
    prod = neg_q ? -{x_n, y_n} : {x_n, y_n};
    dv = op_q[1] ? x_n : y_n;
    fin = op_q[2] ? (neg_q ? -dv : dv) : (op_q[1:0] == 2'd0 ? prod[31:0] : prod[63:32]);
`ifdef MULDIV_EARLY_OUT_EN
    early = bus.MDOpE[2] ? (bus.srcB == 32'd0 || (~bus.MDOpE[0] && bus.srcA == 32'h8000_0000 && bus.srcB == 32'hFFFF_FFFF))
                         : (bus.srcA == 32'd0 || bus.srcB == 32'd0);
    eo_res = ~bus.MDOpE[2] ? 32'd0 : bus.srcB == 32'd0 ? (bus.MDOpE[1] ? bus.srcA : 32'hFFFF_FFFF)
                                                       : (bus.MDOpE[1] ? 32'd0 : 32'h8000_0000);
`endif
  end
  // control FSM: accept, iterate, complete; flush abandons the op without touching the result
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    x_d = x_q;
    y_d = y_q;
    m_d = m_q;
    op_d = op_q;
    neg_d = neg_q;
    res_d = res_q;
    busy = state_q == MUL || state_q == DIV;
    bus.StallE = ~bus.FlushE & (busy | (state_q == IDLE & bus.StartE));
    bus.MDDoneE = state_q == DONE;
    if (bus.FlushE) begin
      state_d = IDLE;
    end else if (busy) begin
      x_d = x_n;
      y_d = y_n;
      cnt_d = cnt_q - 5'd1;
      if (cnt_q == 5'd0) begin
        state_d = DONE;
        res_d = fin;
      end
    end else if (bus.StartE) begin
      op_d = bus.MDOpE;
      cnt_d = 5'd31;
      x_d = 32'd0;
      y_d = bus.MDOpE[2] ? ma : mb;
      m_d = bus.MDOpE[2] ? mb : ma;
      neg_d = bus.MDOpE[2] ? (bus.MDOpE[1] ? sa : (sa ^ sb) & (bus.srcB != 32'd0)) : sa ^ sb;
      state_d = bus.MDOpE[2] ? DIV : MUL;
`ifdef MULDIV_EARLY_OUT_EN
      if (early) begin
        state_d = DONE;
        res_d = eo_res;
      end
`endif
    end else begin
      state_d = IDLE;
    end
  end
  // state and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= 5'd0;
      x_q <= 32'd0;
      y_q <= 32'd0;
      m_q <= 32'd0;
      op_q <= 3'd0;
      neg_q <= 1'b0;
      res_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      x_q <= x_d;
      y_q <= y_d;
      m_q <= m_d;
      op_q <= op_d;
      neg_q <= neg_d;
      res_q <= res_d;
    end
  end
  assign bus.MDResultE = res_q;
endmodule
